// File: rtl/obi_mem_responder.sv
// Responder end of a req/gnt/rvalid memory port: programmable grant stall, fixed in-order response
// latency, bounded outstanding requests. Optional error window enabled by OBI_RESP_ERR_INJECT_EN.
module obi_mem_responder #(
    parameter int unsigned MemWords       = 16384,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned GntStall       = 0,
    parameter int unsigned RespLatency    = 1,
    parameter logic [31:0] ErrBase        = 32'h0001_F000,
    parameter logic [31:0] ErrMask        = 32'hFFFF_F000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IdxW = $clog2(MemWords);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned StW  = (GntStall > 0) ? $clog2(GntStall + 1) : 1;
    localparam int unsigned TmW  = $clog2(RespLatency + 1);

    typedef enum logic {S_IDLE, S_STALL} state_e;

    state_e          state_q, state_d;
    logic [StW-1:0]  stall_q, stall_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     fifo_rdata_q [MaxOutstanding];
    logic [31:0]     fifo_rdata_d [MaxOutstanding];
    logic            fifo_err_q   [MaxOutstanding];
    logic            fifo_err_d   [MaxOutstanding];
    logic [TmW-1:0]  fifo_tmr_q   [MaxOutstanding];
    logic [TmW-1:0]  fifo_tmr_d   [MaxOutstanding];
    logic [31:0]     mem_q        [MemWords];

    logic            fifo_full, gnt, push, pop, err_hit;
    logic [IdxW-1:0] idx;
    logic [31:0]     mem_rd;

    assign idx       = addr_i[IdxW+1:2];
    assign mem_rd    = mem_q[idx];
    // An entry leaving this cycle still counts as occupied, so a grant never relies on the pop.
    assign fifo_full = (cnt_q == CntW'(MaxOutstanding));

`ifdef OBI_RESP_ERR_INJECT_EN
    assign err_hit = ((addr_i & ErrMask) == ErrBase);
    logic unused_addr;
    assign unused_addr = 1'b0;
`else
    assign err_hit = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:IdxW+2], addr_i[1:0], ErrBase, ErrMask};
`endif

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        gnt     = 1'b0;
        if (GntStall == 0) begin
            gnt = req_i && !fifo_full;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        state_d = S_STALL;
                        stall_d = StW'(1);
                    end
                end
                S_STALL: begin
                    if (!req_i) begin
                        state_d = S_IDLE;
                        stall_d = '0;
                    end else if (stall_q == StW'(GntStall)) begin
                        if (!fifo_full) begin
                            gnt     = 1'b1;
                            state_d = S_IDLE;
                            stall_d = '0;
                        end
                    end else begin
                        stall_d = stall_q + StW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    stall_d = '0;
                end
            endcase
        end
    end

    assign push = gnt;
    assign pop  = (cnt_q != '0) && (fifo_tmr_q[rptr_q] == '0);

    always_comb begin
        fifo_rdata_d = fifo_rdata_q;
        fifo_err_d   = fifo_err_q;
        fifo_tmr_d   = fifo_tmr_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q + CntW'(push) - CntW'(pop);
        for (int unsigned i = 0; i < MaxOutstanding; i++) begin
            if (fifo_tmr_q[i] != '0) fifo_tmr_d[i] = fifo_tmr_q[i] - TmW'(1);
        end
        if (push) begin
            fifo_rdata_d[wptr_q] = (we_i || err_hit) ? 32'h0 : mem_rd;
            fifo_err_d[wptr_q]   = err_hit;
            fifo_tmr_d[wptr_q]   = TmW'(RespLatency - 1);
            wptr_d               = ptr_inc(wptr_q);
        end
        if (pop) rptr_d = ptr_inc(rptr_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            stall_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                fifo_rdata_q[i] <= '0;
                fifo_err_q[i]   <= 1'b0;
                fifo_tmr_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            stall_q      <= stall_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            fifo_rdata_q <= fifo_rdata_d;
            fifo_err_q   <= fifo_err_d;
            fifo_tmr_q   <= fifo_tmr_d;
        end
    end

    // Storage is deliberately left unreset, like a real SRAM.
    always_ff @(posedge clk_i) begin
        if (push && we_i && !err_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = pop;
    assign rdata_o  = pop ? fifo_rdata_q[rptr_q] : 32'h0;
    assign err_o    = pop ? fifo_err_q[rptr_q] : 1'b0;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder: three instances (stall 0/lat 1, stall 3/lat 2, stall 0/lat 2).
module tb_obi_mem_responder;

    logic        clk, rst_n;
    logic        req    [3];
    logic        we     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [3:0]  be     [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        obi_mem_responder #(
            .MaxOutstanding(2),
            .GntStall      ((g == 1) ? 3 : 0),
            .RespLatency   ((g == 0) ? 1 : 2)
        ) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .req_i   (req[g]),
            .gnt_o   (gnt[g]),
            .addr_i  (addr[g]),
            .we_i    (we[g]),
            .be_i    (be[g]),
            .wdata_i (wdata[g]),
            .rvalid_o(rvalid[g]),
            .rdata_o (rdata[g]),
            .err_o   (err[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // Monitor: every response must match the oldest expectation for that instance, on time.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rvalid[d]) begin
                int k;
                k = -1;
                for (int i = 0; i < sb.size(); i++) if (k < 0 && sb[i].d == d) k = i;
                if (k < 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid d%0d cyc=%0d got rvalid=1 want 0", d, cyc);
                end else begin
                    if (rdata[d] !== sb[k].rdata || err[d] !== sb[k].err || cyc != sb[k].due) begin
                        errors++;
                        $display("FAIL resp d%0d got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                                 d, rdata[d], err[d], cyc, sb[k].rdata, sb[k].err, sb[k].due);
                    end
                    sb.delete(k);
                end
            end else if (rdata[d] !== 32'h0 || err[d] !== 1'b0 || rvalid[d] !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs d%0d got rvalid=%b rdata=%h err=%b want 0 0 0",
                         d, rvalid[d], rdata[d], err[d]);
            end
        end
    end

    // Called just after a rising edge; returns just after the rising edge following the grant.
    task automatic issue(input int d, input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int exp_wait);
        int   waited;
        bit   got;
        exp_t e;
        waited = -1;
        got    = 0;
        req[d] = 1'b1; addr[d] = a; we[d] = w; be[d] = b; wdata[d] = wd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt[d]) begin
                got    = 1;
                waited = i;
                e.d = d; e.rdata = er; e.err = ee; e.due = cyc + lat_of(d);
                sb.push_back(e);
                break;
            end
            @(posedge clk); #1;
        end
        if (got) begin
            @(posedge clk); #1;
        end else begin
            req[d] = 1'b0;
        end
        checks++;
        if (!got || waited != exp_wait) begin
            errors++;
            $display("FAIL grant_wait d%0d addr=%h got %0d want %0d", d, a, waited, exp_wait);
        end
    endtask

    task automatic idle(input int n);
        for (int d = 0; d < 3; d++) req[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (gnt[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_gnt d%0d got %b want 0", d, gnt[d]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(10);

        // Basic write/read, byte enables, back-to-back throughput and address wrap on instance 0.
        issue(0, 32'h100, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0, 0);
        issue(0, 32'h100, 0, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0);
        idle(2);
        issue(0, 32'h40, 1, 4'hF, 32'h11223344, 32'h0, 0, 0);
        issue(0, 32'h40, 1, 4'b0101, 32'hAABBCCDD, 32'h0, 0, 0);
        issue(0, 32'h40, 0, 4'h0, 32'h0, 32'h11BB33DD, 0, 0);
        issue(0, 32'h200, 1, 4'hF, 32'h12345678, 32'h0, 0, 0);
        issue(0, 32'h100, 0, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0);
        issue(0, 32'h200, 0, 4'hF, 32'h0, 32'h12345678, 0, 0);
        issue(0, 32'h10100, 0, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0);
        idle(3);

        issue(0, 32'h0F010, 1, 4'hF, 32'hCAFEF00D, 32'h0, 0, 0);
`ifdef OBI_RESP_ERR_INJECT_EN
        issue(0, 32'h1F010, 1, 4'hF, 32'h5, 32'h0, 1, 0);
        issue(0, 32'h1F010, 0, 4'hF, 32'h0, 32'h0, 1, 0);
        issue(0, 32'h0F010, 0, 4'hF, 32'h0, 32'hCAFEF00D, 0, 0);
`else
        issue(0, 32'h1F010, 1, 4'hF, 32'h5, 32'h0, 0, 0);
        issue(0, 32'h1F010, 0, 4'hF, 32'h0, 32'h5, 0, 0);
        issue(0, 32'h0F010, 0, 4'hF, 32'h0, 32'h5, 0, 0);
`endif
        idle(3);

        // Grant stall of 3 with req held continuously: one grant every fourth cycle.
        for (int i = 0; i < 4; i++)
            issue(1, 32'(4 * i), 1, 4'hF, 32'h1111_0000 + 32'(i), 32'h0, 0, 3);
        for (int i = 0; i < 4; i++)
            issue(1, 32'(4 * i), 0, 4'hF, 32'h0, 32'h1111_0000 + 32'(i), 0, 3);
        idle(3);
        // Request withdrawn early must restart the stall count from scratch.
        req[1] = 1'b1; addr[1] = 32'h8; we[1] = 1'b0; be[1] = 4'hF;
        repeat (2) @(posedge clk);
        #1 req[1] = 1'b0;
        @(posedge clk); #1;
        issue(1, 32'h8, 0, 4'hF, 32'h0, 32'h1111_0002, 0, 3);
        idle(3);

        // Latency 2 with two slots: grants pause while both slots are occupied.
        issue(2, 32'h0, 1, 4'hF, 32'h0BAD_0001, 32'h0, 0, 0);
        issue(2, 32'h4, 1, 4'hF, 32'h0BAD_0002, 32'h0, 0, 0);
        issue(2, 32'h0, 0, 4'hF, 32'h0, 32'h0BAD_0001, 0, 1);
        issue(2, 32'h4, 0, 4'hF, 32'h0, 32'h0BAD_0002, 0, 0);
        issue(2, 32'h0, 0, 4'hF, 32'h0, 32'h0BAD_0001, 0, 1);
        idle(4);

        // Reset with two responses outstanding: both must vanish.
        issue(2, 32'h0, 0, 4'hF, 32'h0, 32'h0BAD_0001, 0, 0);
        issue(2, 32'h4, 0, 4'hF, 32'h0, 32'h0BAD_0002, 0, 0);
        req[2] = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == 2) sb.delete(i);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        issue(2, 32'h0, 0, 4'hF, 32'h0, 32'h0BAD_0001, 0, 0);
        idle(10);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_resp got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
